// File: rtl/instr_issue_encoder.sv
// Instruction issue encoder.
// Turns NN-core operation requests into 16-bit instruction words
// {opcode, rd, rs, rt_or_offset}. It buffers them in a small FIFO in front of the
// decode stage, drops invalid operations, flags them and counts them.
module instr_issue_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rs,
  input  logic [3:0]       in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instr,
  output logic             err_invalid,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_SLT = 3'd2,
    OP_MAC = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5
  } reqOp_t;

  logic [15:0]     fifoMem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   occupancy;
  logic [3:0]       opcode;
  logic             opValid;
  logic [15:0]      encodedWord;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             accept;
  logic             doPush;
  logic             doPop;

  // Map the request opcode onto the instruction opcode field; ops 6 and 7 are invalid
  always_comb begin
    opcode  = 4'h0;
    opValid = 1'b1;
    case (in_op)
      OP_ADD:  opcode = 4'h1;
      OP_MUL:  opcode = 4'h2;
      OP_SLT:  opcode = 4'h3;
      OP_MAC:  opcode = 4'h4;
      OP_LD:   opcode = 4'hE;
      OP_ST:   opcode = 4'hF;
      default: opValid = 1'b0;
    endcase
    encodedWord = {opcode, in_rd, in_rs, in_rt};
  end

  assign fifoFull  = (occupancy == OCC_FULL);
  assign fifoEmpty = (occupancy == '0);
  assign in_ready  = !fifoFull;
  assign out_valid = !fifoEmpty;
  assign out_instr = fifoEmpty ? 16'h0000 : fifoMem[rdPtr];

  assign accept = in_valid && in_ready;
  assign doPush = accept && opValid;
  assign doPop  = out_valid && out_ready;

  // Storage array needs no reset: the empty flag masks stale contents at the output
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem[wrPtr] <= encodedWord;
    end
  end

  // Pointers and occupancy; a reset discards everything still buffered
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Error pulse and saturating issued/error counters
  always_ff @(posedge clk) begin
    if (reset) begin
      err_invalid <= 1'b0;
      issued_cnt  <= '0;
      err_cnt     <= '0;
    end else begin
      err_invalid <= accept && !opValid;
      if (doPop && (issued_cnt != '1)) begin
        issued_cnt <= issued_cnt + CNT_ONE;
      end
      if (accept && !opValid && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Self-checking bench for instr_issue_encoder.
// A table of single requests with fixed expected words comes first. Hand-written
// sequences then cover the full FIFO, the invalid-op pulse, back-to-back
// push/pop and a mid-operation reset. A scoreboard queue checks issue order.
module tb_instr_issue_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic        err_invalid;
  logic [15:0] issued_cnt;
  logic [15:0] err_cnt;

  int checks;
  int failures;
  logic [15:0] expQ[$];

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] expWord;
    logic        expErr;
  } vec_t;

  vec_t vecs[8];

  instr_issue_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_rd(in_rd),
    .in_rs(in_rs),
    .in_rt(in_rt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .err_invalid(err_invalid),
    .issued_cnt(issued_cnt),
    .err_cnt(err_cnt)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference encoding of a request
  function automatic logic [15:0] modelWord(input logic [2:0] op, input logic [3:0] rd,
                                            input logic [3:0] rs, input logic [3:0] rt);
    logic [3:0] opc;
    case (op)
      3'd0:    opc = 4'h1;
      3'd1:    opc = 4'h2;
      3'd2:    opc = 4'h3;
      3'd3:    opc = 4'h4;
      3'd4:    opc = 4'hE;
      3'd5:    opc = 4'hF;
      default: opc = 4'h0;
    endcase
    return {opc, rd, rs, rt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt);
    in_valid = v;
    in_op    = op;
    in_rd    = rd;
    in_rs    = rs;
    in_rt    = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare on every consumed word, then record newly accepted requests
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedIssue", {16'h0, out_instr}, 32'hFFFF_FFFF);
          end else begin
            checkOutput("issueOrder", {16'h0, out_instr}, {16'h0, expQ.pop_front()});
          end
        end
        if (in_valid && in_ready && (in_op < 3'd6)) begin
          expQ.push_back(modelWord(in_op, in_rd, in_rs, in_rt));
        end
      end
    end
  end

  // Main test sequence
  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);

    vecs[0] = '{3'd0, 4'hA, 4'hB, 4'hC, 16'h1ABC, 1'b0};
    vecs[1] = '{3'd1, 4'h1, 4'h2, 4'h3, 16'h2123, 1'b0};
    vecs[2] = '{3'd2, 4'hF, 4'h0, 4'h9, 16'h3F09, 1'b0};
    vecs[3] = '{3'd3, 4'h7, 4'h7, 4'h7, 16'h4777, 1'b0};
    vecs[4] = '{3'd4, 4'h5, 4'h2, 4'h7, 16'hE527, 1'b0};
    vecs[5] = '{3'd5, 4'h5, 4'h2, 4'h7, 16'hF527, 1'b0};
    vecs[6] = '{3'd6, 4'h1, 4'h1, 4'h1, 16'h0000, 1'b1};
    vecs[7] = '{3'd7, 4'h2, 4'h2, 4'h2, 16'h0000, 1'b1};

    step();
    step();
    reset = 1'b0;

    // Reset state
    checkOutput("rstOutValid", {31'h0, out_valid}, 32'd0);
    checkOutput("rstOutInstr", {16'h0, out_instr}, 32'h0);
    checkOutput("rstInReady", {31'h0, in_ready}, 32'd1);
    checkOutput("rstErr", {31'h0, err_invalid}, 32'd0);
    checkOutput("rstIssued", {16'h0, issued_cnt}, 32'd0);
    checkOutput("rstErrCnt", {16'h0, err_cnt}, 32'd0);

    // T1: single ADD, visible one cycle after acceptance
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd0, 4'h3, 4'h1, 4'h2);
    checkOutput("t1NoBypass", {31'h0, out_valid}, 32'd0);
    step();
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    checkOutput("t1Valid", {31'h0, out_valid}, 32'd1);
    checkOutput("t1Instr", {16'h0, out_instr}, 32'h1312);
    step();
    checkOutput("t1Issued", {16'h0, issued_cnt}, 32'd1);
    checkOutput("t1Empty", {31'h0, out_valid}, 32'd0);

    // Table of single requests (covers T3 LD/ST and invalid ops)
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt);
      step();
      applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
      checkOutput($sformatf("vecErr%0d", i), {31'h0, err_invalid}, {31'h0, vecs[i].expErr});
      if (vecs[i].expErr) begin
        checkOutput($sformatf("vecDrop%0d", i), {31'h0, out_valid}, 32'd0);
      end else begin
        checkOutput($sformatf("vecWord%0d", i), {16'h0, out_instr}, {16'h0, vecs[i].expWord});
      end
      step();
    end
    checkOutput("tblIssued", {16'h0, issued_cnt}, 32'd7);
    checkOutput("tblErrCnt", {16'h0, err_cnt}, 32'd2);

    // T4: invalid op while one entry is buffered
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 4'h4, 4'h5, 4'h6);
    step();
    applyStimulus(1'b1, 3'd6, 4'h9, 4'h9, 4'h9);
    step();
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    checkOutput("t4ErrPulse", {31'h0, err_invalid}, 32'd1);
    checkOutput("t4ErrCnt", {16'h0, err_cnt}, 32'd3);
    step();
    checkOutput("t4ErrOnce", {31'h0, err_invalid}, 32'd0);
    checkOutput("t4Head", {16'h0, out_instr}, 32'h1456);
    out_ready = 1'b1;
    step();
    checkOutput("t4Drained", {31'h0, out_valid}, 32'd0);
    checkOutput("t4Issued", {16'h0, issued_cnt}, 32'd8);

    // T2: fill the FIFO, hold, reject extra requests, then drain in order
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 4'h1, 4'h2, 4'h3);
    step();
    applyStimulus(1'b1, 3'd2, 4'h4, 4'h5, 4'h6);
    step();
    applyStimulus(1'b1, 3'd3, 4'h7, 4'h8, 4'h9);
    step();
    checkOutput("t2NotFullYet", {31'h0, in_ready}, 32'd1);
    applyStimulus(1'b1, 3'd4, 4'hA, 4'hB, 4'hC);
    step();
    checkOutput("t2Full", {31'h0, in_ready}, 32'd0);
    applyStimulus(1'b1, 3'd0, 4'h1, 4'h1, 4'h1);
    step();
    checkOutput("t2StillFull", {31'h0, in_ready}, 32'd0);
    checkOutput("t2Hold", {16'h0, out_instr}, 32'h2123);
    applyStimulus(1'b1, 3'd7, 4'h0, 4'h0, 4'h0);
    step();
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    checkOutput("t2InvalidWhileFull", {31'h0, err_invalid}, 32'd0);
    checkOutput("t2ErrCnt", {16'h0, err_cnt}, 32'd3);
    checkOutput("t2HoldValid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    step();
    step();
    step();
    checkOutput("t2Drained", {31'h0, out_valid}, 32'd0);
    checkOutput("t2Issued", {16'h0, issued_cnt}, 32'd12);

    // T5: two entries buffered, then push and pop together for 10 cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 4'h1, 4'h0, 4'h0);
    step();
    applyStimulus(1'b1, 3'd1, 4'h2, 4'h0, 4'h0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 3'(i % 6), 4'(i), 4'(i + 3), 4'(15 - i));
      step();
    end
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    checkOutput("t5Issued", {16'h0, issued_cnt}, 32'd22);
    checkOutput("t5Occupied", {31'h0, out_valid}, 32'd1);
    checkOutput("t5NotFull", {31'h0, in_ready}, 32'd1);
    step();
    step();
    checkOutput("t5Drained", {31'h0, out_valid}, 32'd0);
    checkOutput("t5IssuedAll", {16'h0, issued_cnt}, 32'd24);

    // T6: reset with three entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd2, 4'(i), 4'h1, 4'h1);
      step();
    end
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    checkOutput("t6Buffered", {31'h0, out_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expQ.delete();
    checkOutput("t6OutValid", {31'h0, out_valid}, 32'd0);
    checkOutput("t6OutInstr", {16'h0, out_instr}, 32'h0);
    checkOutput("t6InReady", {31'h0, in_ready}, 32'd1);
    checkOutput("t6Issued", {16'h0, issued_cnt}, 32'd0);
    checkOutput("t6ErrCnt", {16'h0, err_cnt}, 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd0, 4'h3, 4'h1, 4'h2);
    step();
    applyStimulus(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    checkOutput("t6NextWord", {16'h0, out_instr}, 32'h1312);
    step();
    checkOutput("t6NextIssued", {16'h0, issued_cnt}, 32'd1);
    checkOutput("t6Empty", {31'h0, out_valid}, 32'd0);

    step();
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
